// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable bit divisor
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [15:0] div, per, bcnt;
  logic [2:0] bidx;
  logic [7:0] sh;
  logic ovf, tx_n, pop, load, push, full, empty, last, busy;
  logic wr_data, wr_stat, wr_div, unused;
  assign unused  = ^{addr[1:0], wdata[31:16]};
  assign sel     = addr[31:4] == BASE_ADDR[31:4] && addr[3:2] != 2'd3;
  assign wr_data = we && sel && addr[3:2] == 2'd0;
  assign wr_stat = we && sel && addr[3:2] == 2'd1;
  assign wr_div  = we && sel && addr[3:2] == 2'd2;
  assign full    = count == CW'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign push    = wr_data && !full;
  assign last    = bcnt == per - 16'd1;
  assign busy    = state != IDLE;
  always_comb begin
    rdata = !sel ? 32'd0 :
            addr[3:2] == 2'd1 ? {25'd0, 3'(count), ovf, busy, empty, full} :
            addr[3:2] == 2'd2 ? {16'd0, div} : 32'd0;
  end
  // load marks the first clock of a new bit period; the divisor is captured there
  always_comb begin
    state_n = state;
    tx_n    = tx;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1; load = 1'b1; tx_n = 1'b0; state_n = START;
      end
      START: if (last) begin
        load = 1'b1; tx_n = sh[0]; state_n = DATA;
      end
      DATA: if (last) begin
        load    = 1'b1;
        tx_n    = bidx == 3'd7 ? 1'b1 : sh[bidx + 3'd1];
        state_n = bidx == 3'd7 ? STOP : DATA;
      end
      STOP: if (last) begin
        pop     = !empty;
        load    = !empty;
        tx_n    = empty;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      div   <= 16'(CLKS_PER_BIT);
      per   <= 16'd1;
      bcnt  <= '0;
      bidx  <= '0;
      sh    <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      bcnt  <= (load || state == IDLE) ? 16'd0 : bcnt + 16'd1;
      per   <= load ? div : per;
      count <= count + CW'(push) - CW'(pop);
      ovf   <= (wr_data && full) || (ovf && !(wr_stat && wdata[3]));
      if (pop) begin
        sh   <= mem[rp];
        rp   <= rp + 1'b1;
        bidx <= '0;
      end else if (state == DATA && last)
        bidx <= bidx + 3'd1;
      if (push)
        wp <= wp + 1'b1;
      if (wr_div)
        div <= wdata[15:0] == 16'd0 ? 16'd1 : wdata[15:0];
    end
  end
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= wdata[7:0];
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a per-clock line model
module tb_mmio_uart_tx;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  logic sel, tx;
  int total = 0, bad = 0;
  bit q[$];
  localparam logic [31:0] TXD = 32'h200, STS = 32'h204, DIV = 32'h208;

  mmio_uart_tx dut (.clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
                    .rdata(rdata), .sel(sel), .tx(tx));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  // an 8N1 frame is start(0), eight data bits LSB first, stop(1), each held d clocks
  task automatic frame(input logic [7:0] b, input int d);
    for (int k = 0; k < 10; k++)
      repeat (d) q.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1]);
  endtask

  task automatic expect_line(input string tag, input int skip);
    repeat (skip) void'(q.pop_front());
    while (q.size() > 0) begin
      chk(tag, {31'd0, tx}, {31'd0, q.pop_front()});
      step();
    end
    chk({tag, "_idle"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    int d;
    logic [7:0] rb [3];
    bit seen_low;
    step(); step();
    reset = 1'b0;
    rd("rst_status", STS, 32'h02);
    rd("rst_div", DIV, 32'd16);
    rd("rst_txdata", TXD, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    addr = 32'h64; #1;
    chk("sel_64", {31'd0, sel}, 32'd0);
    chk("rdata_64", rdata, 32'd0);
    addr = 32'h20C; #1;
    chk("sel_20c", {31'd0, sel}, 32'd0);
    addr = 32'h208; #1;
    chk("sel_208", {31'd0, sel}, 32'd1);

    wr(DIV, 32'd4);
    rd("div4", DIV, 32'd4);
    wr(TXD, 32'hA5);
    chk("a5_pre_tx", {31'd0, tx}, 32'd1);
    rd("a5_queued", STS, 32'h10);
    step();
    rd("a5_busy", STS, 32'h06);
    frame(8'hA5, 4);
    expect_line("a5_line", 0);
    rd("a5_done", STS, 32'h02);

    for (int i = 0; i < 6; i++) begin
      wr(TXD, 32'h11 + i);
      if (i == 4) rd("burst_full", STS, 32'h45);
    end
    rd("burst_ovf", STS, 32'h4D);
    for (int i = 0; i < 5; i++) frame(8'h11 + 8'(i), 4);
    expect_line("burst_line", 4);
    rd("burst_done", STS, 32'h0A);
    wr(STS, 32'h07);
    rd("ovf_kept", STS, 32'h0A);
    wr(STS, 32'h08);
    rd("ovf_clear", STS, 32'h02);

    wr(DIV, 32'd0);
    rd("div0", DIV, 32'd1);
    wr(TXD, 32'h00);
    step();
    frame(8'h00, 1);
    expect_line("zero_line", 0);

    d = $urandom_range(6, 1);
    wr(DIV, 32'(d));
    rd("rnd_div", DIV, 32'(d));
    for (int i = 0; i < 3; i++) begin
      rb[i] = 8'($urandom);
      wr(TXD, {24'd0, rb[i]});
    end
    for (int i = 0; i < 3; i++) frame(rb[i], d);
    expect_line("rnd_line", 1);
    rd("rnd_done", STS, 32'h02);

    wr(DIV, 32'd4);
    wr(TXD, 32'hF0);
    wr(TXD, 32'hA1);
    wr(TXD, 32'hB2);
    repeat (8) step();
    rd("mid_busy", STS, 32'h24);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    rd("mid_rst_status", STS, 32'h02);
    rd("mid_rst_div", DIV, 32'd16);
    seen_low = 1'b0;
    repeat (400) begin
      step();
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    chk("mid_rst_quiet", {31'd0, seen_low}, 32'd0);
    rd("mid_rst_final", STS, 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
